// File: rtl/tama_pkg.sv
// Shared types and constants for the tamagotchi status UART transmitter.
// Optional parity support is selected with the TAMA_TX_PARITY_EN macro.
package tama_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic TX_IDLE_LEVEL = 1'b1;
    localparam int   DATA_BITS     = 8;

    // Bits on the line per frame: start + data + optional parity + stop.
    function automatic int frame_bits();
`ifdef TAMA_TX_PARITY_EN
        return DATA_BITS + 3;
`else
        return DATA_BITS + 2;
`endif
    endfunction

endpackage

// File: rtl/tama_baud_tick.sv
// Bit-time counter for the status transmitter. Counts 0..CLKS_PER_BIT-1
// while running and pulses bit_done on the final count of each bit time.
module tama_baud_tick #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic restart,
    output logic bit_done
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign bit_done = run && (cnt == LAST);

    // Free-running bit timer; parked at zero while idle, zeroed on launch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || !run) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tama_status_tx.sv
// UART (8N1, or 8E1 with TAMA_TX_PARITY_EN) transmitter for the pet status
// byte. Frames launch on status change (AUTO_SEND) or on send_i requests;
// requests arriving while busy or disabled collapse into one pending flag.
module tama_status_tx
    import tama_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10,
    parameter int AUTO_SEND    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] status_i,
    input  logic       send_i,
    output logic       tx_o,
    output logic       busy_o,
    output logic       pending_o,
    output logic [7:0] frames_o
);

    tx_state_t  state;
    logic [7:0] shreg;
    logic [7:0] last_sent;
    logic [2:0] bit_idx;
    logic       bit_done;
    logic       auto_hit;
    logic       launch;
`ifdef TAMA_TX_PARITY_EN
    logic       parity;
`endif

    assign auto_hit = (AUTO_SEND != 0) && (status_i != last_sent);
    assign launch   = (state == IDLE) && ena && (pending_o || send_i || auto_hit);

    tama_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (state != IDLE),
        .restart (launch),
        .bit_done(bit_done)
    );

    // Frame sequencer: line level, shift register, request latch and frame count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tx_o      <= TX_IDLE_LEVEL;
            busy_o    <= 1'b0;
            pending_o <= 1'b0;
            frames_o  <= 8'd0;
            shreg     <= 8'd0;
            last_sent <= 8'd0;
            bit_idx   <= 3'd0;
`ifdef TAMA_TX_PARITY_EN
            parity    <= 1'b0;
`endif
        end else begin
            // A launch consumes any request, including one arriving this cycle.
            pending_o <= launch ? 1'b0 : (pending_o | send_i);

            case (state)
                IDLE: begin
                    if (launch) begin
                        state     <= START;
                        tx_o      <= 1'b0;
                        busy_o    <= 1'b1;
                        shreg     <= status_i;
                        last_sent <= status_i;
`ifdef TAMA_TX_PARITY_EN
                        parity    <= ^status_i;
`endif
                    end
                end
                START: begin
                    if (bit_done) begin
                        state   <= DATA;
                        tx_o    <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= 3'd0;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef TAMA_TX_PARITY_EN
                            state <= PARITY;
                            tx_o  <= parity;
`else
                            state <= STOP;
                            tx_o  <= TX_IDLE_LEVEL;
`endif
                        end else begin
                            tx_o    <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
`ifdef TAMA_TX_PARITY_EN
                PARITY: begin
                    if (bit_done) begin
                        state <= STOP;
                        tx_o  <= TX_IDLE_LEVEL;
                    end
                end
`endif
                STOP: begin
                    if (bit_done) begin
                        state    <= IDLE;
                        busy_o   <= 1'b0;
                        frames_o <= frames_o + 8'd1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_o   <= TX_IDLE_LEVEL;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tama_status_tx.sv
// Bench for tama_status_tx: an AUTO_SEND=1 instance (line-decoded by a
// monitor against a queue of expected bytes) and an AUTO_SEND=0 instance
// for request/pending behaviour.
module tb_tama_status_tx;

    localparam int CPB = 4;
`ifdef TAMA_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena_a = 1'b1, send_a = 1'b0;
    logic [7:0] status_a = 8'h00;
    logic       tx_a, busy_a, pend_a;
    logic [7:0] frames_a;
    logic       ena_m = 1'b1, send_m = 1'b0;
    logic [7:0] status_m = 8'h66;
    logic       tx_m, busy_m, pend_m;
    logic [7:0] frames_m;

    int         checks = 0;
    int         failures = 0;
    int         rst_cnt = 0;
    logic [7:0] exp_q[$];

    typedef struct packed {
        logic [7:0] st;
        logic [7:0] fr;
    } vec_t;
    vec_t vecs[5];

    always #5 clk = ~clk;
    always @(negedge rst_n) rst_cnt = rst_cnt + 1;

    tama_status_tx #(.CLKS_PER_BIT(CPB), .AUTO_SEND(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .ena(ena_a), .status_i(status_a), .send_i(send_a),
        .tx_o(tx_a), .busy_o(busy_a), .pending_o(pend_a), .frames_o(frames_a));

    tama_status_tx #(.CLKS_PER_BIT(CPB), .AUTO_SEND(0)) dut_m (
        .clk(clk), .rst_n(rst_n), .ena(ena_m), .status_i(status_m), .send_i(send_m),
        .tx_o(tx_m), .busy_o(busy_m), .pending_o(pend_m), .frames_o(frames_m));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Expected line level k cycles after the launch cycle of byte d.
    function automatic logic exp_line(input logic [7:0] d, input int k);
        int idx;
        idx = (k - 1) / CPB;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (FB == 11 && idx == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic wait_a(input int n, input string nm);
        int t;
        for (t = 0; t < 400; t++) begin
            if (frames_a == 8'(n) && !busy_a) break;
            @(negedge clk);
        end
        if (t == 400) $display("FAIL %s_timeout actual=frames %0d required=%0d", nm, frames_a, n);
        chk({nm, "_frames"}, frames_a, n);
        chk({nm, "_busy"}, busy_a, 0);
    endtask

    task automatic wait_m(input int n, input string nm);
        int t;
        for (t = 0; t < 400; t++) begin
            if (frames_m == 8'(n) && !busy_m) break;
            @(negedge clk);
        end
        chk({nm, "_frames"}, frames_m, n);
        chk({nm, "_busy"}, busy_m, 0);
    endtask

    // Line monitor: decode each frame mid-bit, compare with the next expected byte.
    initial begin : mon
        logic [10:0] fr;
        logic [7:0]  e;
        int          r0;
        bit          abort;
        forever begin
            @(negedge tx_a);
            if (rst_n) begin
                r0 = rst_cnt;
                abort = 0;
                fr = '0;
                for (int i = 0; i < FB; i++) begin
                    repeat ((i == 0) ? 2 : CPB) @(negedge clk);
                    if (rst_cnt != r0) begin
                        abort = 1;
                        break;
                    end
                    fr[i] = tx_a;
                end
                if (!abort) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL mon_unexpected_frame actual=%0h required=none", fr[8:1]);
                    end else begin
                        e = exp_q.pop_front();
                        chk("mon_start", fr[0], 0);
                        chk("mon_data", fr[8:1], e);
                        if (FB == 11) chk("mon_parity", fr[9], ^e);
                        chk("mon_stop", fr[FB-1], 1);
                    end
                end
            end
        end
    end

    initial begin : guard
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : main
        int         bad;
        logic [7:0] last;

        vecs[0] = '{8'h5A, 8'd3};
        vecs[1] = '{8'hFF, 8'd4};
        vecs[2] = '{8'h01, 8'd5};
        vecs[3] = '{8'h01, 8'd5};
        vecs[4] = '{8'h80, 8'd6};

        repeat (3) @(negedge clk);
        chk("reset_tx", tx_a, 1);
        chk("reset_busy", busy_a, 0);
        rst_n = 1'b1;

        // status 0 after reset matches last_sent: nothing goes out
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || busy_a !== 1'b0) bad++;
        end
        chk("idle_hold_line", bad, 0);
        chk("idle_frames", frames_a, 0);
        chk("idle_pending", pend_a, 0);
        chk("idle_m_frames", frames_m, 0);

        // cycle-exact 0xA5 frame, with 3C then 3D arriving mid-frame
        status_a = 8'hA5;
        exp_q.push_back(8'hA5);
        for (int k = 1; k <= CPB * FB + 2; k++) begin
            @(negedge clk);
            if (k <= CPB * FB) begin
                chk($sformatf("a5_line_k%0d", k), tx_a, exp_line(8'hA5, k));
                chk($sformatf("a5_busy_k%0d", k), busy_a, 1);
            end else if (k == CPB * FB + 1) begin
                chk("a5_done_frames", frames_a, 1);
                chk("a5_done_busy", busy_a, 0);
                chk("a5_done_line", tx_a, 1);
            end else begin
                chk("b2b_start", tx_a, 0);
                chk("b2b_busy", busy_a, 1);
            end
            if (k == 10) status_a = 8'h3C;
            if (k == 20) begin
                status_a = 8'h3D;
                exp_q.push_back(8'h3D);
            end
        end
        wait_a(2, "newest_only");
        last = 8'h3D;

        // table of auto-send vectors (repeat value must not send)
        for (int i = 0; i < 5; i++) begin
            status_a = vecs[i].st;
            if (vecs[i].st != last) exp_q.push_back(vecs[i].st);
            last = vecs[i].st;
            repeat (2) @(negedge clk);
            wait_a(int'(vecs[i].fr), $sformatf("vec%0d", i));
        end

        // manual-send instance: launch, then three requests while busy
        send_m = 1'b1;
        @(negedge clk);
        send_m = 1'b0;
        chk("m_launch_busy", busy_m, 1);
        chk("m_launch_no_pending", pend_m, 0);
        for (int i = 0; i < 3; i++) begin
            repeat (3) @(negedge clk);
            send_m = 1'b1;
            @(negedge clk);
            send_m = 1'b0;
        end
        chk("m_pending_set", pend_m, 1);
        bad = 0;
        while (frames_m != 8'd1 && bad < 200) begin
            @(negedge clk);
            bad++;
        end
        repeat (2) @(negedge clk);
        chk("m_extra_busy", busy_m, 1);
        chk("m_extra_pending_clr", pend_m, 0);
        wait_m(2, "m_extra");
        repeat (60) @(negedge clk);
        chk("m_only_one_extra", frames_m, 2);
        status_m = 8'h67;
        repeat (60) @(negedge clk);
        chk("m_no_auto", frames_m, 2);

        // ena low mid-frame with a request: frame finishes, request held
        status_a = 8'h11;
        exp_q.push_back(8'h11);
        repeat (10) @(negedge clk);
        ena_a = 1'b0;
        send_a = 1'b1;
        @(negedge clk);
        send_a = 1'b0;
        wait_a(7, "ena_low_finish");
        repeat (20) @(negedge clk);
        chk("ena_low_idle", busy_a, 0);
        chk("ena_low_pending", pend_a, 1);
        chk("ena_low_frames", frames_a, 7);
        ena_a = 1'b1;
        exp_q.push_back(8'h11);
        @(negedge clk);
        chk("ena_high_launch", busy_a, 1);
        chk("ena_high_pending_clr", pend_a, 0);
        wait_a(8, "ena_resume");

        // reset during data bit 3: line high at once, full frame after release
        status_a = 8'h42;
        for (int k = 1; k <= 19; k++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_line", tx_a, 1);
        chk("midreset_busy", busy_a, 0);
        chk("midreset_frames", frames_a, 0);
        repeat (6) @(negedge clk);
        exp_q.push_back(8'h42);
        rst_n = 1'b1;
        wait_a(1, "after_reset");

`ifdef TAMA_TX_PARITY_EN
        status_a = 8'h07;
        exp_q.push_back(8'h07);
        for (int k = 1; k <= CPB * FB; k++) begin
            @(negedge clk);
            if (k == 38) chk("parity_bit_07", tx_a, 1);
            if (k == 42) chk("stop_after_parity", tx_a, 1);
        end
        wait_a(2, "parity_frame");
`endif

        repeat (10) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
